reg_bit_response_checker: RTL
=============================

Name: reg_bit_response_checker

Overview:
- Receive-side companion to the bit-stimulus drivers used around registered single-bit cells (e.g. d_flip_flop with d in, y out).
- Taps the stimulus bit driven into a DUT and the DUT's output bit.
- Delays the stimulus by a fixed pipeline latency and compares it against the DUT output every cycle.
- Reports checked count, error count, first-failure index and pass/fail; synthesizable, so it can live on-chip beside the cell under test or inside benches.

Parameters:
- LATENCY, 1, DUT clock-edge latency from stim_d to dut_y; legal range 1..16.
- CNT_W, 16, width of checked_cnt, error_cnt and first_err_idx.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse: clear results and begin checking.
- stop  input  1  single-cycle pulse: end stimulus capture, then drain in-flight samples.
- stim_d  input  1  bit currently driven into the DUT's d input.
- dut_y  input  1  DUT output bit.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- fail  output  1  sticky; high once any mismatch is seen in the current run.
- checked_cnt  output  CNT_W  number of comparisons performed.
- error_cnt  output  CNT_W  number of mismatches.
- first_err_idx  output  CNT_W  sample index k of the first mismatch; valid only when fail=1.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Delay line data and valid bits are cleared.
  - busy, done, fail, checked_cnt, error_cnt and first_err_idx all go to 0.
  - Reset mid-run aborts the run immediately with no drain.
- Delay line: LATENCY stages; each stage holds {valid, data}.
- States and transitions:
  - IDLE: waits for start.
  - start in IDLE or DONE:
    - Clears the counters, fail and first_err_idx.
    - Captures stim_d into stage 0 with valid=1 as sample 0.
    - Moves to RUN.
  - RUN:
    - Each edge shifts the delay line and captures stim_d with valid=1.
    - Sample k is the value captured on edge T0+k.
    - stop in RUN goes to DRAIN; the stop cycle itself captures with valid=0.
    - start in RUN is ignored.
    - If stop and start are asserted together in RUN, stop wins.
  - DRAIN: each edge shifts in valid=0. Moves to DONE on the edge after which no stage holds valid=1 (exactly LATENCY edges after stop).
  - DONE: holds all results and asserts done. start restarts the run; stop is ignored.
- stop in IDLE or DONE is ignored. start and stop together in IDLE: start wins.
- Comparison:
  - On each edge in RUN or DRAIN where the tail stage is valid, compare dut_y (as sampled on that edge) with the tail data.
  - Sample k is therefore compared at edge T0+k+LATENCY.
  - For a plain DFF with LATENCY=1: stim_d=1 captured at edge E is checked against dut_y at edge E+1.
  - Each comparison increments checked_cnt.
  - A mismatch increments error_cnt and sets fail.
  - On the first mismatch, first_err_idx takes the pre-increment value of checked_cnt (that value equals k).
- Arithmetic: checked_cnt and error_cnt saturate at 2^CNT_W-1 and never wrap. Saturation does not alter fail or the state sequence.
- Outputs are registered and update on the same edge as the comparison; no combinational input-to-output paths.

Optional Feature:
- Macro: RBRC_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch moves the FSM straight to DONE on that edge, from RUN or DRAIN.
  - In-flight samples are discarded.
  - The mismatch cycle still updates checked_cnt, error_cnt, fail and first_err_idx, so error_cnt is at most 1.
- Undefined: checking continues through all samples as specified in Behaviour.

Test Plan:
- Pass, LATENCY=1, ideal DFF as DUT:
  - Stimulus: start; stim_d sequence 0,1,0,1 on four consecutive edges; stop on the next cycle.
  - Expected after drain: done=1, checked_cnt=4, error_cnt=0, fail=0, busy=0.
  - Expected timing: done asserts exactly LATENCY edges after the stop edge.
- Single fault:
  - Stimulus: same sequence, with dut_y forced to 0 on the cycle sample 1 is compared.
  - Expected: error_cnt=1, fail=1, first_err_idx=1, checked_cnt=4.
- LATENCY=3:
  - Stimulus: DUT is a 3-stage shift register; 8 random bits; stop.
  - Expected: checked_cnt=8, error_cnt=0; busy stays high for 3 edges after stop, then done=1.
  - Fault case: dut_y tied to 1 with stimulus all 0 gives error_cnt=8 and first_err_idx=0.
- Control corner cases:
  - Stimulus: start pulse in RUN; start+stop together in RUN; stop in IDLE.
  - Expected: start in RUN is ignored; start+stop in RUN enters DRAIN; stop in IDLE keeps IDLE with all outputs 0.
- Reset mid-run:
  - Stimulus: assert reset 2 samples into RUN, then start again with all-good data.
  - Expected: all outputs 0 after reset; the next run counts only new samples (checked_cnt starts from 0).
- Saturation and optional feature:
  - Stimulus: CNT_W=4; 20 mismatching samples.
  - Expected: checked_cnt=15, error_cnt=15, fail=1.
  - With RBRC_STOP_ON_ERR_EN defined: done=1 on the first mismatch edge, with error_cnt=1 and checked_cnt=1.

Source files
------------

// File: rtl/reg_bit_response_checker.sv
// Delays a tapped stimulus bit by LATENCY edges and compares it against a registered cell's output.
// Optional macro RBRC_STOP_ON_ERR_EN ends the run on the first mismatch.
module reg_bit_response_checker #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             stim_d,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] error_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [LATENCY-1:0] line_v;
  logic [LATENCY-1:0] line_d;
  logic [LATENCY-1:0] nxt_v;
  logic [LATENCY-1:0] nxt_d;
  logic               cap_v;
  logic               cmp_en;
  logic               mismatch;
  logic               line_live;

  // Stage 0 takes a valid sample on the start edge and on every non-stop RUN edge.
  always_comb begin
    cap_v = 1'b0;
    case (state)
      IDLE, DONE: cap_v = start;
      RUN:        cap_v = !stop;
      default:    cap_v = 1'b0;
    endcase
  end

  always_comb begin
    nxt_v = line_v;
    nxt_d = line_d;
    for (int i = int'(LATENCY) - 1; i > 0; i--) begin
      nxt_v[i] = line_v[i-1];
      nxt_d[i] = line_d[i-1];
    end
    nxt_v[0] = cap_v;
    nxt_d[0] = stim_d;
  end

  always_comb begin
    cmp_en    = ((state == RUN) || (state == DRAIN)) && line_v[LATENCY-1];
    mismatch  = cmp_en && (dut_y != line_d[LATENCY-1]);
    line_live = |line_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      line_v        <= '0;
      line_d        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      checked_cnt   <= '0;
      error_cnt     <= '0;
      first_err_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            fail          <= 1'b0;
            checked_cnt   <= '0;
            error_cnt     <= '0;
            first_err_idx <= '0;
            line_v        <= nxt_v;
            line_d        <= nxt_d;
          end
        end

        RUN, DRAIN: begin
          line_v <= nxt_v;
          line_d <= nxt_d;

          // Counters saturate; first_err_idx latches the pre-increment count once.
          if (cmp_en) begin
            if (checked_cnt != CNT_MAX) checked_cnt <= checked_cnt + CNT_W'(1);
            if (mismatch) begin
              if (error_cnt != CNT_MAX) error_cnt <= error_cnt + CNT_W'(1);
              if (!fail) first_err_idx <= checked_cnt;
              fail <= 1'b1;
            end
          end

          if (state == RUN) begin
            if (stop) state <= DRAIN;
          end else if (!line_live) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end

`ifdef RBRC_STOP_ON_ERR_EN
          if (mismatch) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            line_v <= '0;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
